act_wb_packer: RTL and testbench

- Downstream of the h_swish requantization stage.
- Takes the stream of 8-bit requantized activations, one per handshake, and packs four into a 32-bit word.
- Writes the packed words to the output activation buffer (GLB) at consecutive word addresses from a per-tile base.
- Ends each tile with a partial-word flush and a one-cycle done pulse.

---
 rtl/act_wb_packer.sv | 152 +++++++++++++++
 tb/tb_act_wb_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_wb_packer.sv
// Packs a stream of 8-bit activations into 32-bit little-endian words and writes them
// to consecutive buffer addresses. Optional ACT_WB_ZERO_CNT_EN adds a per-tile zero counter.
module act_wb_packer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_act,
    input  logic [7:0]        act_in,
    input  logic              act_in_valid,
    output logic              act_in_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              done
`ifdef ACT_WB_ZERO_CNT_EN
    ,
    output logic [CNT_W-1:0]  zero_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] word_cnt;
    logic [1:0]        lane_idx;
    logic [31:0]       pack;
    logic [31:0]       merged;
    logic [3:0]        strb_fill;
    logic              act_hs;
    logic              wr_hs;
    logic              last_act;
    logic              word_done;

    assign act_hs    = act_in_valid && act_in_ready;
    assign wr_hs     = wr_valid && wr_ready;
    assign last_act  = (remaining == CNT_W'(1));
    assign word_done = act_hs && ((lane_idx == 2'd3) || last_act);

    // Lanes above lane_idx are already zero because pack clears after each emitted word.
    always_comb begin
        merged = pack;
        merged[lane_idx*8 +: 8] = act_in;
    end

    always_comb begin
        case (lane_idx)
            2'd0:    strb_fill = 4'b0001;
            2'd1:    strb_fill = 4'b0011;
            2'd2:    strb_fill = 4'b0111;
            default: strb_fill = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_act == '0) ? DONE : PACK;
                end
            end
            PACK: begin
                if (act_hs && last_act) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_hs) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        act_in_ready = (state == PACK) && (!wr_valid || wr_ready);
        busy         = (state != IDLE);
        done         = (state == DONE);
    end

    // A new word may load in the same cycle the held word handshakes, so its address
    // accounts for the word_cnt increment happening in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            remaining <= '0;
            word_cnt  <= '0;
            lane_idx  <= '0;
            pack      <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_strb   <= '0;
`ifdef ACT_WB_ZERO_CNT_EN
            zero_cnt  <= '0;
`endif
        end else begin
            if (wr_hs) begin
                wr_valid <= 1'b0;
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            if (state == IDLE && start) begin
                base_q    <= base_addr;
                remaining <= num_act;
                word_cnt  <= '0;
                lane_idx  <= '0;
                pack      <= '0;
`ifdef ACT_WB_ZERO_CNT_EN
                zero_cnt  <= '0;
`endif
            end
            if (act_hs) begin
                remaining <= remaining - CNT_W'(1);
                lane_idx  <= lane_idx + 2'd1;
                if (word_done) begin
                    pack     <= '0;
                    wr_valid <= 1'b1;
                    wr_data  <= merged;
                    wr_strb  <= strb_fill;
                    wr_addr  <= base_q + word_cnt + ADDR_W'(wr_hs);
                end else begin
                    pack <= merged;
                end
`ifdef ACT_WB_ZERO_CNT_EN
                if (act_in == 8'h00) begin
                    zero_cnt <= zero_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_act_wb_packer.sv
// Scoreboard bench for act_wb_packer: directed tiles push expected words, a monitor
// pops and compares on every write handshake. Define ACT_WB_ZERO_CNT_EN to cover zero_cnt.
module tb_act_wb_packer;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_act;
    logic [7:0]        act_in;
    logic              act_in_valid;
    logic              act_in_ready;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              busy;
    logic              done;
`ifdef ACT_WB_ZERO_CNT_EN
    logic [CNT_W-1:0]  zero_cnt;
`endif

    act_wb_packer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_act      (num_act),
        .act_in       (act_in),
        .act_in_valid (act_in_valid),
        .act_in_ready (act_in_ready),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .busy         (busy),
        .done         (done)
`ifdef ACT_WB_ZERO_CNT_EN
        ,
        .zero_cnt     (zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wexp_t;

    wexp_t sb[$];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    bit    ready_seen = 0;
    bit    wv_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_word(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        wexp_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        sb.push_back(e);
    endtask

    // Monitor: compare every accepted write against the head of the scoreboard.
    always @(negedge clk) begin
        wexp_t e;
        if (act_in_ready) ready_seen = 1'b1;
        if (wr_valid) wv_seen = 1'b1;
        if (!rst && wr_valid && wr_ready) begin
            last_hs_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h@%h with no expected word", wr_data, wr_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
                chk("wr_strb", 32'(wr_strb), 32'(e.strb));
            end
        end
    end

    task automatic start_tile(input logic [15:0] b, input logic [15:0] n);
        start     = 1'b1;
        base_addr = b;
        num_act   = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        act_in_valid = 1'b1;
        act_in       = b;
        do begin
            @(negedge clk);
            hs = act_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 100);
        act_in_valid = 1'b0;
        if (!hs) begin
            checks++;
            $display("FAIL send_timeout: byte %h not accepted, required within 100 cycles", b);
        end
    endtask

    task automatic wait_done(output int dcyc, output int waited);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        dcyc   = cyc;
        waited = n;
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        int wt;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_act = '0;
        act_in = '0; act_in_valid = 1'b0; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(act_in_ready), 32'd0);
        chk("rst_wr_strb", 32'(wr_strb), 32'd0);

        // Full words, always ready
        wr_ready = 1'b1;
        expect_word(16'h0010, 32'h04030201, 4'b1111);
        expect_word(16'h0011, 32'h08070605, 4'b1111);
        start_tile(16'h0010, 16'd8);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done(dc, wt);
        chk("t1_done_latency", 32'(dc), 32'(last_hs_cyc + 1));

        // Partial tail
        expect_word(16'h0100, 32'hDDCCBBAA, 4'b1111);
        expect_word(16'h0101, 32'h0000FFEE, 4'b0011);
        start_tile(16'h0100, 16'd6);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        chk("t2_no_early_word", 32'(wr_valid), 32'd0);
        send_byte(8'hDD);
        chk("t2_word_latency", 32'(wr_valid), 32'd1);
        send_byte(8'hEE); send_byte(8'hFF);
        wait_done(dc, wt);

        // Backpressure on word 0
        wr_ready = 1'b0;
        expect_word(16'h0200, 32'h14131211, 4'b1111);
        expect_word(16'h0201, 32'h18171615, 4'b1111);
        start_tile(16'h0200, 16'd8);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i));
        act_in_valid = 1'b1;
        act_in       = 8'h15;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_wr_valid", 32'(wr_valid), 32'd1);
            chk("bp_wr_data", wr_data, 32'h14131211);
            chk("bp_wr_addr", 32'(wr_addr), 32'h0200);
            chk("bp_ready_low", 32'(act_in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(8'(8'h11 + i));
        wait_done(dc, wt);

        // Empty tile
        ready_seen = 1'b0;
        wv_seen    = 1'b0;
        start_tile(16'h0300, 16'd0);
        wait_done(dc, wt);
        chk("t4_done_wait", 32'(wt), 32'd1);
        chk("t4_no_ready", 32'(ready_seen), 32'd0);
        chk("t4_no_write", 32'(wv_seen), 32'd0);

        // Address wrap
        expect_word(16'hFFFF, 32'h24232221, 4'b1111);
        expect_word(16'h0000, 32'h28272625, 4'b1111);
        start_tile(16'hFFFF, 16'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i));
        wait_done(dc, wt);

        // Reset mid-tile, then a fresh tile
        start_tile(16'hFFFF, 16'd8);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(act_in_ready), 32'd0);
        expect_word(16'h0400, 32'h00333231, 4'b0111);
        start_tile(16'h0400, 16'd3);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        wait_done(dc, wt);

        // Zero activations
        expect_word(16'h0500, 32'h00000500, 4'b1111);
        expect_word(16'h0501, 32'h0000007F, 4'b0001);
        start_tile(16'h0500, 16'd5);
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h7F);
        wait_done(dc, wt);
`ifdef ACT_WB_ZERO_CNT_EN
        chk("zero_cnt_held", 32'(zero_cnt), 32'd3);
`endif
        expect_word(16'h0600, 32'h00000009, 4'b0001);
        start_tile(16'h0600, 16'd1);
`ifdef ACT_WB_ZERO_CNT_EN
        chk("zero_cnt_cleared", 32'(zero_cnt), 32'd0);
`endif
        send_byte(8'h09);
        wait_done(dc, wt);
`ifdef ACT_WB_ZERO_CNT_EN
        chk("zero_cnt_nonzero_byte", 32'(zero_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
